demux_memoria1x4_4bitsconductual: RTL
=====================================

# demux_memoria1x4_4bitsconductual

Registered 1-to-4 demultiplexer with valid, the receive-side counterpart of the 4x1 valid mux. It takes one 4-bit stream qualified by `valid_input` and steers each valid nibble to one of four output lanes. Each lane holds its last value in memory and raises a one-cycle lane valid. An internal round-robin pointer can take the place of the external selector, and a fill tracker pulses `word_valid` once all four lanes have been refreshed. This lets the block rebuild a 4-lane word that was serialized by the 4x1 mux cycling its selector.

## Interface
- `WIDTH`, 4, data width of the input and of each output lane.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset; takes precedence over every other input.
- `auto_sel`  input  1  1: the lane is chosen by internal `lane_ptr`; 0: the lane is chosen by `selector1x4`.
- `selector1x4`  input  2  external lane select, used only when `auto_sel`=0.
- `valid_input`  input  1  qualifies `data_in_1x4_4b` in the current cycle.
- `data_in_1x4_4b`  input  WIDTH  input data.
- `data_out0_1x4_4b` .. `data_out3_1x4_4b`  output  WIDTH each  registered lane data; each lane holds its value until written again.
- `valid_out0` .. `valid_out3`  output  1 each  registered one-cycle pulse marking the lane written on the previous edge.
- `word_valid`  output  1  registered one-cycle pulse when all four lanes have been written since the last clear.
- `lane_ptr`  output  2  current round-robin pointer.

## Operation
- Effective select: `sel = auto_sel ? lane_ptr : selector1x4`.
- Write occurs when `valid_input`=1 at an edge:
  - `data_out[sel]` <= `data_in_1x4_4b`; the other lanes hold.
  - `valid_out[sel]` <= 1; the other valid outputs <= 0.
- No write when `valid_input`=0: all `valid_outN` <= 0 and all data outputs hold. This is the memory behaviour; outputs never return to zero except on reset.
- `lane_ptr`:
  - Increments modulo 4 on each write while `auto_sel`=1; wraps 3 -> 0.
  - Holds while `auto_sel`=0 or when there is no write.
  - Toggling `auto_sel` never resets it; auto mode resumes from the held value.
- Fill tracker: internal 4-bit `fill_mask` with two states.
  - EMPTY: mask = 0000.
  - FILLING: mask nonzero.
  - On a write, the next mask is `fill_mask | (1<<sel)`.
  - If that result equals 1111: `word_valid` <= 1 and mask <= 0000 (return to EMPTY) on the same edge.
  - Otherwise `word_valid` <= 0.
  - The tracker runs in both select modes.
  - Rewriting an already-set lane overwrites the data, leaves the mask unchanged, and does not fire `word_valid`.
- Reset, whenever asserted at an edge:
  - All `data_outN` = 0, all `valid_outN` = 0, `word_valid` = 0, `lane_ptr` = 0, `fill_mask` = 0000.
  - A `valid_input` in the same cycle is discarded.
  - A partly filled word is lost.
- `selector1x4` and `auto_sel` are sampled only at the edge; changes between edges have no effect.

## Timing
- Latency: 1 cycle from `valid_input`/data sampled at edge N to `data_outN`/`valid_outN` visible after edge N.
- `word_valid` asserts in the same cycle as the `valid_outN` of the write that completes the word.
- Throughput: one nibble per cycle with no stall. There is no back-pressure; the downstream must accept each pulse.
- Back-to-back valids in auto mode hit lanes 0,1,2,3,0,... with `word_valid` on every fourth write.
- All outputs come straight from flops; there is no combinational path from input to output.

## Test plan
- Reset, then auto mode: apply `reset` for 2 cycles, then `auto_sel`=1 and valid data 0x1,0x2,0x3,0x4 on consecutive cycles.
  - While in reset: all outputs 0.
  - Data outputs: lanes 0..3 = 1,2,3,4.
  - Valid outputs: `valid_out0..3` pulse in successive cycles.
  - `word_valid`=1 only with `valid_out3`; `lane_ptr` back at 0.
- Gaps: `auto_sel`=1 with the valid pattern 1,0,1,0,1,1 carrying data A,x,B,x,C,D.
  - Lanes 0..3 = A,B,C,D.
  - No `valid_outN` during the idle cycles; data holds through the gaps.
  - `word_valid` fires once, after D.
- Manual mode with a duplicate: `auto_sel`=0, writes with (sel,data) = (2,0x9),(2,0xA),(0,0x5),(1,0x6),(3,0x7).
  - Lane 2 = 0xA; lanes 0,1,3 = 0x5,0x6,0x7.
  - `word_valid` fires only on the lane-3 write.
  - `lane_ptr` stays 0 throughout.
- Mode switch: `auto_sel`=1 for two writes (`lane_ptr`=2), then `auto_sel`=0 with one write to sel=3, then `auto_sel`=1 for one write.
  - The manual write lands in lane 3 and `lane_ptr` stays 2.
  - The next auto write goes to lane 2 and `lane_ptr` becomes 3.
- Reset mid-word: three auto writes (0xF,0xE,0xD), then `reset` asserted together with `valid_input`=1 and data 0xC.
  - All outputs 0 and `lane_ptr`=0; 0xC is not captured.
  - Four new writes are needed before the next `word_valid`.
- Wrap: 9 consecutive auto writes.
  - `lane_ptr` sequence 1,2,3,0,1,2,3,0,1.
  - `word_valid` pulses after writes 4 and 8 only.

Source files
------------

// File: rtl/demux_memoria1x4_4bitsconductual.sv
// Registered 1-to-4 demultiplexer with per-lane memory and one-cycle lane valids.
// A round-robin pointer can replace the external select; a fill tracker flags a completed 4-lane word.
module demux_memoria1x4_4bitsconductual #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             auto_sel,
  input  logic [1:0]       selector1x4,
  input  logic             valid_input,
  input  logic [WIDTH-1:0] data_in_1x4_4b,
  output logic [WIDTH-1:0] data_out0_1x4_4b,
  output logic [WIDTH-1:0] data_out1_1x4_4b,
  output logic [WIDTH-1:0] data_out2_1x4_4b,
  output logic [WIDTH-1:0] data_out3_1x4_4b,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             valid_out2,
  output logic             valid_out3,
  output logic             word_valid,
  output logic [1:0]       lane_ptr,
  output logic             dbg_fill_state_o,
  output logic [3:0]       dbg_fill_mask_o
);

  // Handshake: valid_input qualifies data_in for the edge it is sampled on; there is
  // no ready, so every qualified nibble is accepted and each output pulse lasts one cycle.

  typedef enum logic {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } fill_state_e;

  fill_state_e      fill_state_q;
  logic [3:0]       fill_mask_q;
  logic [3:0]       fill_mask_d;
  logic [1:0]       lane_ptr_q;
  logic [1:0]       sel_d;
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic             word_valid_q;
  logic             word_done_d;

  always_comb begin
    sel_d       = auto_sel ? lane_ptr_q : selector1x4;
    fill_mask_d = fill_mask_q | (4'b0001 << sel_d);
    word_done_d = (fill_mask_d == 4'b1111);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
      valid_q      <= 4'b0000;
      word_valid_q <= 1'b0;
      lane_ptr_q   <= 2'd0;
      fill_mask_q  <= 4'b0000;
      fill_state_q <= EMPTY;
    end else begin
      // Pulses default low; data lanes hold unless written.
      valid_q      <= 4'b0000;
      word_valid_q <= 1'b0;
      if (valid_input) begin
        data_q[sel_d]  <= data_in_1x4_4b;
        valid_q[sel_d] <= 1'b1;
        if (auto_sel) lane_ptr_q <= lane_ptr_q + 2'd1;
        case (fill_state_q)
          EMPTY, FILLING: begin
            if (word_done_d) begin
              word_valid_q <= 1'b1;
              fill_mask_q  <= 4'b0000;
              fill_state_q <= EMPTY;
            end else begin
              fill_mask_q  <= fill_mask_d;
              fill_state_q <= FILLING;
            end
          end
          default: begin
            fill_mask_q  <= 4'b0000;
            fill_state_q <= EMPTY;
          end
        endcase
      end
    end
  end

  assign data_out0_1x4_4b = data_q[0];
  assign data_out1_1x4_4b = data_q[1];
  assign data_out2_1x4_4b = data_q[2];
  assign data_out3_1x4_4b = data_q[3];
  assign valid_out0       = valid_q[0];
  assign valid_out1       = valid_q[1];
  assign valid_out2       = valid_q[2];
  assign valid_out3       = valid_q[3];
  assign word_valid       = word_valid_q;
  assign lane_ptr         = lane_ptr_q;
  assign dbg_fill_state_o = fill_state_q;
  assign dbg_fill_mask_o  = fill_mask_q;

endmodule
